// File: rtl/id_fwd_stage_pkg.sv
// Shared constants and types for the ID stage with operand forwarding.
// Widths here are the defaults; modules take their own width parameters.
package id_fwd_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N_FWD  = 2;
  localparam int DEF_CNT_W  = 16;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD    = '0;
  localparam logic [DEF_ADDR_W-1:0] NOP_REG_ADDR = '0;

  // What the ID/EX register does on the next rising edge, highest priority first.
  typedef enum logic [1:0] {
    UPD_FLUSH  = 2'd0,
    UPD_HOLD   = 2'd1,
    UPD_BUBBLE = 2'd2,
    UPD_LOAD   = 2'd3
  } upd_e;

endpackage

// File: rtl/id_fwd_stage_if.sv
// Bundle of decode-side inputs, forwarding sources and ID/EX outputs.
// The master drives decode/forwarding; the slave is the ID stage itself.
interface id_fwd_stage_if import id_fwd_stage_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_FWD  = DEF_N_FWD,
  parameter int CNT_W  = DEF_CNT_W
);

  // Handshake: id_valid_i offers one decoded instruction; it is consumed on
  // the rising edge where id_ready_o=1 and must stay presented until then.
  // id_ready_o is combinational on id_valid_i, the hazard check, stall and flush.
  logic                    id_valid_i;
  logic                    rs_read_i;
  logic                    rt_read_i;
  logic [ADDR_W-1:0]       rs_addr_i;
  logic [ADDR_W-1:0]       rt_addr_i;
  logic [DATA_W-1:0]       imm_i;
  logic [ADDR_W-1:0]       wd_i;
  logic                    wreg_i;
  logic [DATA_W-1:0]       reg1_data_i;
  logic [DATA_W-1:0]       reg2_data_i;
  logic [N_FWD-1:0]        fwd_wreg_i;
  logic [N_FWD*ADDR_W-1:0] fwd_wd_i;
  logic [N_FWD*DATA_W-1:0] fwd_wdata_i;
  logic [N_FWD-1:0]        fwd_ready_i;
  logic                    stall_i;
  logic                    flush_i;
  logic                    id_ready_o;
  logic                    stall_req_o;
  logic                    ex_valid_o;
  logic                    ex_wreg_o;
  logic [DATA_W-1:0]       ex_reg1_o;
  logic [DATA_W-1:0]       ex_reg2_o;
  logic [ADDR_W-1:0]       ex_wd_o;
  logic [CNT_W-1:0]        stall_cnt_o;

  modport master (
    output id_valid_i, rs_read_i, rt_read_i, rs_addr_i, rt_addr_i, imm_i,
           wd_i, wreg_i, reg1_data_i, reg2_data_i, fwd_wreg_i, fwd_wd_i,
           fwd_wdata_i, fwd_ready_i, stall_i, flush_i,
    input  id_ready_o, stall_req_o, ex_valid_o, ex_wreg_o, ex_reg1_o,
           ex_reg2_o, ex_wd_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, rs_read_i, rt_read_i, rs_addr_i, rt_addr_i, imm_i,
           wd_i, wreg_i, reg1_data_i, reg2_data_i, fwd_wreg_i, fwd_wd_i,
           fwd_wdata_i, fwd_ready_i, stall_i, flush_i,
    output id_ready_o, stall_req_o, ex_valid_o, ex_wreg_o, ex_reg1_o,
           ex_reg2_o, ex_wd_o, stall_cnt_o
  );

endinterface

// File: rtl/id_operand_sel.sv
// Resolves one source operand: immediate, hard-wired zero register,
// youngest matching forwarding source, or register-file data.
module id_operand_sel import id_fwd_stage_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_FWD  = DEF_N_FWD
) (
  input  logic                    read_en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       imm,
  input  logic [DATA_W-1:0]       reg_data,
  input  logic [N_FWD-1:0]        fwd_wreg,
  input  logic [N_FWD*ADDR_W-1:0] fwd_wd,
  input  logic [N_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [N_FWD-1:0]        fwd_ready,
  output logic [DATA_W-1:0]       operand,
  output logic                    hazard
);

  always_comb begin
    operand = DATA_W'(ZERO_WORD);
    hazard  = 1'b0;
    if (!read_en) begin
      operand = imm;
    end else if (addr != ADDR_W'(NOP_REG_ADDR)) begin
      operand = reg_data;
      // Walk oldest to youngest so the lowest-index match is the last write.
      for (int i = N_FWD - 1; i >= 0; i--) begin
        if (fwd_wreg[i] && (fwd_wd[i*ADDR_W +: ADDR_W] == addr)) begin
          operand = fwd_wdata[i*DATA_W +: DATA_W];
          hazard  = !fwd_ready[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_fwd_stage.sv
// Decode stage operand forwarding, load-use hazard detection, ID/EX
// pipeline register and saturating hazard-stall counter.
module id_fwd_stage import id_fwd_stage_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_FWD  = DEF_N_FWD,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst,
  id_fwd_stage_if.slave bus
);

  logic [DATA_W-1:0] rs_operand;
  logic [DATA_W-1:0] rt_operand;
  logic              rs_hazard;
  logic              rt_hazard;
  logic              hazard;
  upd_e              upd;

  logic              ex_valid_q;
  logic              ex_wreg_q;
  logic [DATA_W-1:0] ex_reg1_q;
  logic [DATA_W-1:0] ex_reg2_q;
  logic [ADDR_W-1:0] ex_wd_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  id_operand_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_FWD(N_FWD)) u_rs_sel (
    .read_en   (bus.rs_read_i),
    .addr      (bus.rs_addr_i),
    .imm       (bus.imm_i),
    .reg_data  (bus.reg1_data_i),
    .fwd_wreg  (bus.fwd_wreg_i),
    .fwd_wd    (bus.fwd_wd_i),
    .fwd_wdata (bus.fwd_wdata_i),
    .fwd_ready (bus.fwd_ready_i),
    .operand   (rs_operand),
    .hazard    (rs_hazard)
  );

  id_operand_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_FWD(N_FWD)) u_rt_sel (
    .read_en   (bus.rt_read_i),
    .addr      (bus.rt_addr_i),
    .imm       (bus.imm_i),
    .reg_data  (bus.reg2_data_i),
    .fwd_wreg  (bus.fwd_wreg_i),
    .fwd_wd    (bus.fwd_wd_i),
    .fwd_wdata (bus.fwd_wdata_i),
    .fwd_ready (bus.fwd_ready_i),
    .operand   (rt_operand),
    .hazard    (rt_hazard)
  );

  // Reset masks the combinational handshake outputs as well as the registers.
  assign hazard = !rst && bus.id_valid_i && (rs_hazard || rt_hazard);

  always_comb begin
    upd = UPD_LOAD;
    if (bus.flush_i)      upd = UPD_FLUSH;
    else if (bus.stall_i) upd = UPD_HOLD;
    else if (hazard)      upd = UPD_BUBBLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_wreg_q   <= 1'b0;
      ex_reg1_q   <= '0;
      ex_reg2_q   <= '0;
      ex_wd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      case (upd)
        UPD_FLUSH, UPD_BUBBLE: begin
          ex_valid_q <= 1'b0;
          ex_wreg_q  <= 1'b0;
          ex_reg1_q  <= '0;
          ex_reg2_q  <= '0;
          ex_wd_q    <= '0;
        end
        UPD_HOLD: ;
        default: begin
          ex_valid_q <= bus.id_valid_i;
          ex_wreg_q  <= bus.wreg_i && bus.id_valid_i;
          ex_reg1_q  <= rs_operand;
          ex_reg2_q  <= rt_operand;
          ex_wd_q    <= bus.wd_i;
        end
      endcase
      if (upd == UPD_BUBBLE && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_req_o = hazard;
  assign bus.id_ready_o  = !rst && bus.id_valid_i && !hazard && !bus.stall_i && !bus.flush_i;
  assign bus.ex_valid_o  = ex_valid_q;
  assign bus.ex_wreg_o   = ex_wreg_q;
  assign bus.ex_reg1_o   = ex_reg1_q;
  assign bus.ex_reg2_o   = ex_reg2_q;
  assign bus.ex_wd_o     = ex_wd_q;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Self-checking bench for id_fwd_stage: directed forwarding/hazard cases,
// random traffic against a reference model, async reset and counter saturation.
module tb_id_fwd_stage;
  import id_fwd_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N_FWD  = 2;
  localparam int CNT_W  = 16;
  localparam int CNT_W_B = 4;
  localparam int EXP_W  = 2 + ADDR_W + 2 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  id_fwd_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_FWD(N_FWD), .CNT_W(CNT_W))   bus_a ();
  id_fwd_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_FWD(N_FWD), .CNT_W(CNT_W_B)) bus_b ();

  id_fwd_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_FWD(N_FWD), .CNT_W(CNT_W)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  id_fwd_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_FWD(N_FWD), .CNT_W(CNT_W_B)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // ---------------- stimulus state ----------------
  logic              t_valid, t_rs_read, t_rt_read, t_wreg, t_stall, t_flush;
  logic [ADDR_W-1:0] t_rs, t_rt, t_wd;
  logic [DATA_W-1:0] t_imm, t_r1, t_r2;
  logic              f_wreg [N_FWD];
  logic              f_rdy  [N_FWD];
  logic [ADDR_W-1:0] f_wd   [N_FWD];
  logic [DATA_W-1:0] f_wdata[N_FWD];

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] m_ex;
  logic [CNT_W-1:0] m_cnt;
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] ex_now();
    return {bus_a.ex_valid_o, bus_a.ex_wreg_o, bus_a.ex_wd_o, bus_a.ex_reg1_o, bus_a.ex_reg2_o};
  endfunction

  // Reference operand: returns {hazard, value}
  function automatic logic [DATA_W:0] ref_opnd(input logic rd, input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] regd);
    logic found;
    logic [DATA_W:0] res;
    if (!rd) return {1'b0, t_imm};
    if (a == 0) return {1'b0, {DATA_W{1'b0}}};
    found = 1'b0;
    res = {1'b0, regd};
    for (int i = 0; i < N_FWD; i++) begin
      if (!found && f_wreg[i] && f_wd[i] == a) begin
        found = 1'b1;
        res = {!f_rdy[i], f_wdata[i]};
      end
    end
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_stim();
    t_valid = 0; t_rs_read = 0; t_rt_read = 0; t_wreg = 0; t_stall = 0; t_flush = 0;
    t_rs = '0; t_rt = '0; t_wd = '0; t_imm = '0; t_r1 = '0; t_r2 = '0;
    for (int i = 0; i < N_FWD; i++) begin
      f_wreg[i] = 0; f_rdy[i] = 1; f_wd[i] = '0; f_wdata[i] = '0;
    end
  endtask

  task automatic apply();
    bus_a.id_valid_i  = t_valid;
    bus_a.rs_read_i   = t_rs_read;
    bus_a.rt_read_i   = t_rt_read;
    bus_a.rs_addr_i   = t_rs;
    bus_a.rt_addr_i   = t_rt;
    bus_a.imm_i       = t_imm;
    bus_a.wd_i        = t_wd;
    bus_a.wreg_i      = t_wreg;
    bus_a.reg1_data_i = t_r1;
    bus_a.reg2_data_i = t_r2;
    bus_a.stall_i     = t_stall;
    bus_a.flush_i     = t_flush;
    for (int i = 0; i < N_FWD; i++) begin
      bus_a.fwd_wreg_i[i]                   = f_wreg[i];
      bus_a.fwd_ready_i[i]                  = f_rdy[i];
      bus_a.fwd_wd_i[i*ADDR_W +: ADDR_W]    = f_wd[i];
      bus_a.fwd_wdata_i[i*DATA_W +: DATA_W] = f_wdata[i];
    end
  endtask

  task automatic model_reset();
    m_ex = '0;
    m_cnt = '0;
    exp_q.delete();
  endtask

  // One clock: check combinational outputs, predict, then compare registers.
  task automatic cycle();
    logic [DATA_W:0] o1, o2;
    logic haz, rdy;
    logic [EXP_W-1:0] nxt, got_exp;
    apply();
    @(negedge clk);
    o1 = ref_opnd(t_rs_read, t_rs, t_r1);
    o2 = ref_opnd(t_rt_read, t_rt, t_r2);
    haz = t_valid && (o1[DATA_W] || o2[DATA_W]);
    rdy = t_valid && !haz && !t_stall && !t_flush;
    check_eq("stall_req", bus_a.stall_req_o, haz);
    check_eq("id_ready", bus_a.id_ready_o, rdy);
    if (t_flush) nxt = '0;
    else if (t_stall) nxt = m_ex;
    else if (haz) begin
      nxt = '0;
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end else nxt = {t_valid, t_wreg && t_valid, t_wd, o1[DATA_W-1:0], o2[DATA_W-1:0]};
    m_ex = nxt;
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    got_exp = exp_q.pop_front();
    check_eq("ex_regs", ex_now(), got_exp);
    check_eq("stall_cnt", bus_a.stall_cnt_o, m_cnt);
    check_eq("wreg_without_valid", bus_a.ex_wreg_o && !bus_a.ex_valid_o, 1'b0);
  endtask

  task automatic pulse_reset_mid_cycle();
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_ex", ex_now(), '0);
    check_eq("async_rst_cnt", bus_a.stall_cnt_o, '0);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [CNT_W-1:0] cnt_save;
    clear_stim();
    apply();
    bus_b.id_valid_i = 0; bus_b.rs_read_i = 0; bus_b.rt_read_i = 0;
    bus_b.rs_addr_i = '0; bus_b.rt_addr_i = '0; bus_b.imm_i = '0;
    bus_b.wd_i = '0; bus_b.wreg_i = 0; bus_b.reg1_data_i = '0; bus_b.reg2_data_i = '0;
    bus_b.fwd_wreg_i = '0; bus_b.fwd_wd_i = '0; bus_b.fwd_wdata_i = '0;
    bus_b.fwd_ready_i = '1; bus_b.stall_i = 0; bus_b.flush_i = 0;
    model_reset();

    // Reset with a would-be hazard presented: everything reads zero.
    #1 rst = 1'b1; rst_b = 1'b1;
    t_valid = 1; t_rs_read = 1; t_rs = 5'd3;
    f_wreg[0] = 1; f_wd[0] = 5'd3; f_rdy[0] = 0;
    apply();
    @(negedge clk);
    check_eq("rst_ex", ex_now(), '0);
    check_eq("rst_cnt", bus_a.stall_cnt_o, '0);
    check_eq("rst_stall_req", bus_a.stall_req_o, 1'b0);
    check_eq("rst_id_ready", bus_a.id_ready_o, 1'b0);
    rst = 1'b0;
    clear_stim();

    // Plain load: rs from register file, rt from immediate.
    t_valid = 1; t_rs_read = 1; t_rs = 5'd3; t_r1 = 32'hAAAA_0001;
    t_rt_read = 0; t_imm = 32'h1234; t_wreg = 1; t_wd = 5'd9;
    cycle();
    check_eq("load_reg2_imm", bus_a.ex_reg2_o, 32'h1234);

    // Both sources match: youngest wins.
    clear_stim();
    t_valid = 1; t_rs_read = 1; t_rs = 5'd5; t_r1 = 32'h5555;
    f_wreg[0] = 1; f_wd[0] = 5'd5; f_wdata[0] = 32'h11;
    f_wreg[1] = 1; f_wd[1] = 5'd5; f_wdata[1] = 32'h22;
    cycle();
    check_eq("fwd_youngest", bus_a.ex_reg1_o, 32'h11);

    // Only the older source matches.
    f_wreg[0] = 0;
    cycle();
    check_eq("fwd_older", bus_a.ex_reg1_o, 32'h22);

    // Young ready match shadows an older pending one: no hazard.
    f_wreg[0] = 1; f_rdy[1] = 0;
    cycle();
    check_eq("fwd_shadow_pending", bus_a.ex_valid_o, 1'b1);

    // Register zero is never forwarded.
    clear_stim();
    t_valid = 1; t_rs_read = 1; t_rs = 5'd0; t_r1 = 32'hBEEF;
    f_wreg[0] = 1; f_wd[0] = 5'd0; f_wdata[0] = 32'hDEAD; f_rdy[0] = 0;
    cycle();
    check_eq("zero_reg", bus_a.ex_reg1_o, 32'h0);

    // Load-use: one bubble, then forwarded data.
    clear_stim();
    t_valid = 1; t_rt_read = 1; t_rt = 5'd7; t_wreg = 1; t_wd = 5'd2;
    f_wreg[0] = 1; f_wd[0] = 5'd7; f_rdy[0] = 0;
    cycle();
    check_eq("bubble_valid", bus_a.ex_valid_o, 1'b0);
    check_eq("bubble_cnt", bus_a.stall_cnt_o, 16'd1);
    f_rdy[0] = 1; f_wdata[0] = 32'h99;
    cycle();
    check_eq("loaduse_reg2", bus_a.ex_reg2_o, 32'h99);
    check_eq("loaduse_cnt", bus_a.stall_cnt_o, 16'd1);

    // Downstream stall holds the ID/EX register for three cycles.
    clear_stim();
    t_valid = 1; t_rs_read = 1; t_rs = 5'd4; t_r1 = 32'hCAFE; t_wreg = 1; t_wd = 5'd6;
    cycle();
    t_stall = 1; t_r1 = 32'hF00D; t_wd = 5'd8;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("stall_hold_reg1", bus_a.ex_reg1_o, 32'hCAFE);

    // Hazard together with flush: flush wins, counter unchanged.
    t_stall = 0; t_flush = 1;
    f_wreg[0] = 1; f_wd[0] = 5'd4; f_rdy[0] = 0;
    cnt_save = bus_a.stall_cnt_o;
    cycle();
    check_eq("flush_hazard_cnt", bus_a.stall_cnt_o, cnt_save);

    // Random traffic over a small address space to provoke matches.
    for (int n = 0; n < 60; n++) begin
      t_valid = ($urandom_range(0, 7) != 0);
      t_rs_read = $urandom_range(0, 1); t_rt_read = $urandom_range(0, 1);
      t_rs = ADDR_W'($urandom_range(0, 3)); t_rt = ADDR_W'($urandom_range(0, 3));
      t_imm = $urandom; t_r1 = $urandom; t_r2 = $urandom;
      t_wreg = $urandom_range(0, 1); t_wd = ADDR_W'($urandom_range(0, 31));
      t_stall = ($urandom_range(0, 7) == 0); t_flush = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N_FWD; i++) begin
        f_wreg[i] = $urandom_range(0, 1); f_wd[i] = ADDR_W'($urandom_range(0, 3));
        f_rdy[i] = ($urandom_range(0, 3) != 0); f_wdata[i] = $urandom;
      end
      cycle();
    end

    // Async reset between edges while an instruction is held by a stall.
    clear_stim();
    t_valid = 1; t_rs_read = 1; t_rs = 5'd2; t_r1 = 32'h55; t_wreg = 1; t_wd = 5'd4;
    cycle();
    t_stall = 1; t_r1 = 32'h66; t_wd = 5'd5;
    cycle();
    check_eq("pre_rst_valid", bus_a.ex_valid_o, 1'b1);
    pulse_reset_mid_cycle();
    t_stall = 0;
    cycle();
    check_eq("post_rst_reg1", bus_a.ex_reg1_o, 32'h66);

    // Narrow counter saturates at all ones.
    @(negedge clk);
    bus_b.id_valid_i = 1; bus_b.rs_read_i = 1; bus_b.rs_addr_i = 5'd3;
    bus_b.fwd_wreg_i = 2'b01; bus_b.fwd_wd_i = {5'd0, 5'd3}; bus_b.fwd_ready_i = 2'b10;
    #1;
    check_eq("b_rst_cnt", bus_b.stall_cnt_o, '0);
    rst_b = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      check_eq("b_sat_cnt", bus_b.stall_cnt_o, (n > 15) ? 15 : n);
    end
    check_eq("b_stall_req", bus_b.stall_req_o, 1'b1);
    check_eq("b_ex_valid", bus_b.ex_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_fwd_stage.md
ID_FWD_STAGE -- requirements
Module: id_fwd_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/data width.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter N_FWD, default 2, number of forwarding sources; index 0 is youngest (EX), highest index oldest.
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 id_valid_i  in  1  decoded instruction present.
REQ-009 rs_read_i, rt_read_i  in  1 each  operand 1/2 read enables.
REQ-010 rs_addr_i, rt_addr_i  in  ADDR_W each  operand register addresses.
REQ-011 imm_i  in  DATA_W  immediate, used when the read enable is 0.
REQ-012 wd_i  in  ADDR_W;  wreg_i  in  1  destination address and write enable.
REQ-013 reg1_data_i, reg2_data_i  in  DATA_W  register-file read data.
REQ-014 fwd_wreg_i  in  N_FWD;  fwd_wd_i  in  N_FWD*ADDR_W;  fwd_wdata_i  in  N_FWD*DATA_W  forwarding sources.
REQ-015 fwd_ready_i  in  N_FWD  source data valid this cycle (0 = pending load).
REQ-016 stall_i  in  1;  flush_i  in  1  downstream stall and flush.
REQ-017 id_ready_o  out  1  instruction accepted this cycle.
REQ-018 stall_req_o  out  1  load-use hazard stall request to fetch.
REQ-019 ex_valid_o, ex_wreg_o  out  1 each;  ex_reg1_o, ex_reg2_o  out  DATA_W each;  ex_wd_o  out  ADDR_W  registered ID/EX outputs.
REQ-020 stall_cnt_o  out  CNT_W  hazard-stall cycle counter.

Function
REQ-021 Operand with read enable 0 SHALL resolve to imm_i, with no hazard.
REQ-022 Operand with read enable 1 and address 0 SHALL resolve to zero, never forwarded, no hazard.
REQ-023 Otherwise the lowest-index source with fwd_wreg_i=1 and matching fwd_wd_i SHALL win; its fwd_wdata_i is used if fwd_ready_i=1, else that operand is hazardous.
REQ-024 No matching source: operand SHALL be reg1_data_i/reg2_data_i.
REQ-025 hazard = id_valid_i AND (operand 1 hazardous OR operand 2 hazardous); stall_req_o = hazard, combinational.
REQ-026 id_ready_o = id_valid_i AND NOT hazard AND NOT stall_i AND NOT flush_i.
REQ-027 Register update priority each rising clk: flush_i > stall_i > hazard > load.
REQ-028 flush_i=1: ex_valid_o, ex_wreg_o, ex_reg1_o, ex_reg2_o, ex_wd_o SHALL become 0.
REQ-029 stall_i=1 (no flush): all ex_* outputs SHALL hold.
REQ-030 hazard=1 (no flush/stall): bubble; ex_valid_o=0, ex_wreg_o=0, data fields 0.
REQ-031 Load: ex_valid_o<=id_valid_i, ex_wreg_o<=wreg_i AND id_valid_i, ex_wd_o<=wd_i, ex_reg1_o/ex_reg2_o <= resolved operands; latency one cycle.
REQ-032 ex_wreg_o SHALL never be 1 while ex_valid_o is 0.
REQ-033 stall_cnt_o SHALL increment by 1 on each clock with hazard=1, stall_i=0, flush_i=0, saturating at all ones (no wrap).
REQ-034 Simultaneous hazard and flush: flush wins; counter does not increment.

Reset
REQ-035 rst=1 SHALL immediately clear all ex_* outputs and stall_cnt_o to 0, independent of clk.
REQ-036 Reset asserted mid-stall SHALL discard the held instruction; first post-reset clock behaves per REQ-027.
REQ-037 Combinational outputs during reset: id_ready_o=0, stall_req_o=0.

Structure
REQ-038 DATA_W, ADDR_W defaults, zero-word and NOP-register-address constants SHALL live in the shared defines file.
REQ-039 Operand resolution SHALL be one sub-module, id_operand_sel, instantiated twice (rs, rt), parametrised by DATA_W, ADDR_W, N_FWD.
REQ-040 Pipeline register and stall counter SHALL reside in id_fwd_stage.

Verification
REQ-041 rs=5 read, fwd0 wd=5 wdata=0x11, fwd1 wd=5 wdata=0x22, both ready -> next cycle ex_reg1_o=0x11.
REQ-042 rs=0 read, fwd0 wreg=1 wd=0 wdata=0xDEAD -> ex_reg1_o=0.
REQ-043 rt=7 read, fwd0 wd=7 ready=0 for 1 cycle then ready=1 wdata=0x99 -> one bubble (ex_valid_o=0, ex_wreg_o=0), stall_req_o=1 one cycle, then ex_reg2_o=0x99, stall_cnt_o=1.
REQ-044 Valid instruction with stall_i=1 for 3 cycles -> ex_* hold prior values, id_ready_o=0, counter unchanged.
REQ-045 hazard and flush_i together -> ex_valid_o=0, stall_cnt_o unchanged; CNT_W=4 with 20 hazard cycles -> stall_cnt_o=0xF.
REQ-046 rst pulsed between clock edges with ex_valid_o=1 -> all ex_* and stall_cnt_o read 0 before next edge.
